// File: rtl/uart_reg_pkg.sv
// Shared types, field positions and helpers for the UART register loader.
package uart_reg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // Command byte layout: bit 7 selects a channel, otherwise slot/nibble.
  localparam int SEL_BIT = 7;
  localparam int SLOT_HI = 6;
  localparam int SLOT_LO = 4;
  localparam int NIB_HI  = 3;
  localparam int NIB_LO  = 0;

  // Clocks per serial bit, rounded to nearest.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_reg_loader_if.sv
// Serial input and register/status outputs of the loader.
interface uart_reg_loader_if #(
  parameter int CHANNELS = 4,
  parameter int REGS     = 4
);
  logic                       rx;
  logic [CHANNELS*REGS*8-1:0] regs_out;
  logic [CHANNELS-1:0]        trig;
  logic [2:0]                 sel_ch;
  logic                       byte_valid;
  logic [7:0]                 rx_byte;
  logic                       frame_err;

  // Host side: drives the serial line, observes the loader.
  modport master (
    output rx,
    input  regs_out, trig, sel_ch, byte_valid, rx_byte, frame_err
  );

  // Loader side.
  modport slave (
    input  rx,
    output regs_out, trig, sel_ch, byte_valid, rx_byte, frame_err
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8-bit UART receiver: synchroniser, bit timer and framing FSM.
module uart_rx_core
  import uart_reg_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int          DIV     = div_calc(CLK_HZ, BAUD);
  localparam logic [15:0] FULL_M1 = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e   state_q, state_d;
  logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic [1:0]  warm_q, warm_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d;
  logic [7:0]  sh_q, sh_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        frame_err_q, frame_err_d;
  logic        tick;

  // State register; synchroniser presets high so an idle line looks idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_s3_q      <= 1'b1;
      warm_q       <= 2'd0;
      cnt_q        <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      sh_q         <= '0;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_s3_q      <= rx_s3_d;
      warm_q       <= warm_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      stop_q       <= stop_d;
      sh_q         <= sh_d;
      byte_valid_q <= byte_valid_d;
      rx_byte_q    <= rx_byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next state. Edge detection stays disarmed until the edge-history flop
  // holds a real pin sample, so a line already low at reset release is
  // not mistaken for a start bit.
  always_comb begin
    state_d      = state_q;
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    rx_s3_d      = rx_s2_q;
    warm_d       = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    tick         = (cnt_q == 16'd0);
    cnt_d        = tick ? cnt_q : cnt_q - 16'd1;
    bit_d        = bit_q;
    stop_d       = stop_q;
    sh_d         = sh_q;
    byte_valid_d = 1'b0;
    rx_byte_d    = rx_byte_q;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (warm_q == 2'd3 && !rx_s2_q && rx_s3_q) begin
          cnt_d   = HALF_M1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s2_q) begin
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_d  = {rx_s2_q, sh_q[7:1]};
          cnt_d = FULL_M1;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!rx_s2_q) begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end else if (stop_q == LAST_STOP) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = sh_q;
            state_d      = IDLE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = FULL_M1;
          end
        end
      end
      BREAK: begin
        if (rx_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign rx_byte    = rx_byte_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_reg_loader.sv
// Serial register loader: decodes slot/nibble bytes into per-channel
// shadow registers and commits a channel atomically on its last slot.
module uart_reg_loader
  import uart_reg_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 9600,
  parameter int CHANNELS  = 4,
  parameter int REGS      = 4,
  parameter int STOP_BITS = 1
) (
  input logic           clk,
  input logic           reset,
  uart_reg_loader_if.slave bus
);

  localparam int RW = REGS * 8;
  localparam int TW = CHANNELS * RW;
  localparam logic [CHANNELS-1:0] ONE = 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ferr;

  logic [2:0]          sel_ch_q, sel_ch_d;
  logic [TW-1:0]       shadow_q, shadow_d;
  logic [TW-1:0]       regs_q, regs_d;
  logic [CHANNELS-1:0] trig_q, trig_d;
  logic [2:0]          slot;
  int                  ch_base;
  int                  nib_base;

  uart_rx_core #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .STOP_BITS(STOP_BITS)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.rx),
    .byte_valid(rx_valid),
    .rx_byte   (rx_data),
    .frame_err (rx_ferr)
  );

  // Channel select, shadow and committed register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_ch_q <= '0;
      shadow_q <= '0;
      regs_q   <= '0;
      trig_q   <= '0;
    end else begin
      sel_ch_q <= sel_ch_d;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
      trig_q   <= trig_d;
    end
  end

  // Byte decode; the commit copy reads shadow_d so it includes the
  // nibble written by the commit byte itself.
  always_comb begin
    sel_ch_d = sel_ch_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    trig_d   = '0;
    slot     = rx_data[SLOT_HI:SLOT_LO];
    ch_base  = int'(sel_ch_q) * RW;
    nib_base = ch_base + int'(slot >> 1) * 8 + (slot[0] ? 4 : 0);
    if (rx_valid) begin
      if (rx_data[SEL_BIT]) begin
        if (int'(rx_data[2:0]) < CHANNELS) sel_ch_d = rx_data[2:0];
      end else if (int'(slot) < 2 * REGS) begin
        shadow_d[nib_base +: 4] = rx_data[NIB_HI:NIB_LO];
        if (int'(slot) == 2 * REGS - 1) begin
          regs_d[ch_base +: RW] = shadow_d[ch_base +: RW];
          trig_d                = ONE << sel_ch_q;
        end
      end
    end
  end

  assign bus.regs_out   = regs_q;
  assign bus.trig       = trig_q;
  assign bus.sel_ch     = sel_ch_q;
  assign bus.byte_valid = rx_valid;
  assign bus.rx_byte    = rx_data;
  assign bus.frame_err  = rx_ferr;

endmodule

// File: tb/tb_uart_reg_loader.sv
// Directed bench for uart_reg_loader: two instances (4x4 regs, 1 stop bit
// and 4x2 regs, 2 stop bits) driven over a shortened bit time.
module tb_uart_reg_loader;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DIV    = 10;

  logic clk;
  logic reset;

  uart_reg_loader_if #(.CHANNELS(4), .REGS(4)) bus0 ();
  uart_reg_loader_if #(.CHANNELS(4), .REGS(2)) bus1 ();

  uart_reg_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNELS(4), .REGS(4), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave)
  );

  uart_reg_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNELS(4), .REGS(2), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int         bv_cnt0 = 0, fe_cnt0 = 0, lat_bad0 = 0;
  int         bv_cnt1 = 0, lat_bad1 = 0;
  int         trig_cyc0 [4] = '{0, 0, 0, 0};
  int         trig_cyc1 [4] = '{0, 0, 0, 0};
  logic [3:0] trig_last0 = '0;
  logic       bv_prev0 = 1'b0, bv_prev1 = 1'b0;

  // Pulse monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus0.byte_valid) bv_cnt0 <= bv_cnt0 + 1;
    if (bus0.frame_err)  fe_cnt0 <= fe_cnt0 + 1;
    if (bus1.byte_valid) bv_cnt1 <= bv_cnt1 + 1;
    for (int c = 0; c < 4; c++) begin
      if (bus0.trig[c]) trig_cyc0[c] <= trig_cyc0[c] + 1;
      if (bus1.trig[c]) trig_cyc1[c] <= trig_cyc1[c] + 1;
    end
    if (bus0.trig != 4'd0) begin
      trig_last0 <= bus0.trig;
      if (!bv_prev0) lat_bad0 <= lat_bad0 + 1;
    end
    if (bus1.trig != 4'd0 && !bv_prev1) lat_bad1 <= lat_bad1 + 1;
    bv_prev0 <= bus0.byte_valid;
    bv_prev1 <= bus1.byte_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input logic [1:0] m, input logic v);
    if (m[0]) bus0.rx = v;
    if (m[1]) bus1.rx = v;
  endtask

  // One frame: start, 8 data bits LSB first, one stop bit of the given
  // level, then three idle bit times (covers a second stop bit).
  task automatic send_frame(input logic [1:0] m, input logic [7:0] b, input logic stop_ok);
    set_rx(m, 1'b0);
    wait_clks(DIV);
    for (int i = 0; i < 8; i++) begin
      set_rx(m, b[i]);
      wait_clks(DIV);
    end
    set_rx(m, stop_ok);
    wait_clks(DIV);
    set_rx(m, 1'b1);
    wait_clks(3 * DIV);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus0.rx = 1'b1;
    bus1.rx = 1'b1;
    wait_clks(4);
    n_vec++;
    if (bus0.regs_out !== 128'd0) begin
      n_err++; $display("FAIL reset_regs0: got %h want 0", bus0.regs_out);
    end
    n_vec++;
    if ({bus0.trig, bus0.sel_ch, bus0.byte_valid, bus0.rx_byte, bus0.frame_err} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_ctl0: trig %b sel %0d bv %b byte %h fe %b want all 0",
               bus0.trig, bus0.sel_ch, bus0.byte_valid, bus0.rx_byte, bus0.frame_err);
    end
    n_vec++;
    if (bus1.regs_out !== 64'd0 || bus1.sel_ch !== 3'd0) begin
      n_err++; $display("FAIL reset_dut1: regs %h sel %0d want 0", bus1.regs_out, bus1.sel_ch);
    end
    reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_load_ch0();
    logic [7:0] seq [8] = '{8'h27, 8'h3A, 8'h02, 8'h18, 8'h4C, 8'h57, 8'h69, 8'h70};
    int bv0 = bv_cnt0;
    int t0  = trig_cyc0[0];
    int tot = trig_cyc0[1] + trig_cyc0[2] + trig_cyc0[3];
    foreach (seq[i]) send_frame(2'b01, seq[i], 1'b1);
    n_vec++;
    if (bus0.regs_out[31:0] !== 32'h097CA782) begin
      n_err++; $display("FAIL load_ch0_regs: got %h want 097ca782", bus0.regs_out[31:0]);
    end
    n_vec++;
    if (bus0.regs_out[127:32] !== 96'd0) begin
      n_err++; $display("FAIL load_other_ch: got %h want 0", bus0.regs_out[127:32]);
    end
    n_vec++;
    if (trig_cyc0[0] - t0 !== 1 || trig_last0 !== 4'b0001) begin
      n_err++; $display("FAIL load_trig: cycles %0d last %b want 1 0001", trig_cyc0[0] - t0, trig_last0);
    end
    n_vec++;
    if (trig_cyc0[1] + trig_cyc0[2] + trig_cyc0[3] - tot !== 0) begin
      n_err++; $display("FAIL load_trig_other: got %0d want 0", trig_cyc0[1] + trig_cyc0[2] + trig_cyc0[3] - tot);
    end
    n_vec++;
    if (lat_bad0 !== 0) begin
      n_err++; $display("FAIL trig_latency: got %0d late pulses want 0", lat_bad0);
    end
    n_vec++;
    if (bv_cnt0 - bv0 !== 8 || bus0.rx_byte !== 8'h70) begin
      n_err++; $display("FAIL load_bytes: count %0d last %h want 8 70", bv_cnt0 - bv0, bus0.rx_byte);
    end
  endtask

  task automatic test_select_ch2();
    logic [7:0] seq [9] = '{8'h82, 8'h23, 8'h39, 8'h0E, 8'h19, 8'h4A, 8'h53, 8'h6A, 8'h70};
    int t2 = trig_cyc0[2];
    foreach (seq[i]) send_frame(2'b01, seq[i], 1'b1);
    n_vec++;
    if (bus0.sel_ch !== 3'd2) begin
      n_err++; $display("FAIL sel_ch2: got %0d want 2", bus0.sel_ch);
    end
    n_vec++;
    if (bus0.regs_out[95:64] !== 32'h0A3A939E) begin
      n_err++; $display("FAIL ch2_regs: got %h want 0a3a939e", bus0.regs_out[95:64]);
    end
    n_vec++;
    if (bus0.regs_out[31:0] !== 32'h097CA782) begin
      n_err++; $display("FAIL ch0_kept: got %h want 097ca782", bus0.regs_out[31:0]);
    end
    n_vec++;
    if (trig_cyc0[2] - t2 !== 1 || trig_last0 !== 4'b0100) begin
      n_err++; $display("FAIL ch2_trig: cycles %0d last %b want 1 0100", trig_cyc0[2] - t2, trig_last0);
    end
  endtask

  task automatic test_partial_commit();
    logic [7:0] seq [4] = '{8'h80, 8'h4F, 8'h5E, 8'h70};
    int t0 = trig_cyc0[0];
    foreach (seq[i]) send_frame(2'b01, seq[i], 1'b1);
    n_vec++;
    if (bus0.regs_out[31:0] !== 32'h09EFA782) begin
      n_err++; $display("FAIL partial_ch0: got %h want 09efa782", bus0.regs_out[31:0]);
    end
    n_vec++;
    if (bus0.regs_out[95:64] !== 32'h0A3A939E) begin
      n_err++; $display("FAIL partial_ch2_kept: got %h want 0a3a939e", bus0.regs_out[95:64]);
    end
    n_vec++;
    if (trig_cyc0[0] - t0 !== 1) begin
      n_err++; $display("FAIL partial_trig: got %0d want 1", trig_cyc0[0] - t0);
    end
  endtask

  task automatic test_frame_err();
    int bv0 = bv_cnt0;
    int fe0 = fe_cnt0;
    send_frame(2'b01, 8'h27, 1'b0);
    n_vec++;
    if (fe_cnt0 - fe0 !== 1 || bv_cnt0 - bv0 !== 0) begin
      n_err++; $display("FAIL bad_stop: fe %0d bv %0d want 1 0", fe_cnt0 - fe0, bv_cnt0 - bv0);
    end
    send_frame(2'b01, 8'h27, 1'b1);
    n_vec++;
    if (bv_cnt0 - bv0 !== 1 || bus0.rx_byte !== 8'h27 || fe_cnt0 - fe0 !== 1) begin
      n_err++; $display("FAIL after_ferr: bv %0d byte %h fe %0d want 1 27 1",
                        bv_cnt0 - bv0, bus0.rx_byte, fe_cnt0 - fe0);
    end
  endtask

  task automatic test_ignore();
    int t0  = trig_cyc0[0] + trig_cyc0[1] + trig_cyc0[2] + trig_cyc0[3];
    int t1  = trig_cyc1[1];
    int bv1 = bv_cnt1;
    send_frame(2'b11, 8'h81, 1'b1);
    send_frame(2'b11, 8'h8F, 1'b1);
    n_vec++;
    if (bus0.sel_ch !== 3'd1 || bus1.sel_ch !== 3'd1) begin
      n_err++; $display("FAIL sel_out_of_range: got %0d/%0d want 1/1", bus0.sel_ch, bus1.sel_ch);
    end
    n_vec++;
    if (trig_cyc0[0] + trig_cyc0[1] + trig_cyc0[2] + trig_cyc0[3] - t0 !== 0) begin
      n_err++; $display("FAIL sel_no_trig: got %0d want 0",
                        trig_cyc0[0] + trig_cyc0[1] + trig_cyc0[2] + trig_cyc0[3] - t0);
    end
    send_frame(2'b10, 8'h7F, 1'b1);
    n_vec++;
    if (trig_cyc1[1] - t1 !== 0 || bus1.regs_out !== 64'd0) begin
      n_err++; $display("FAIL slot_out_of_range: trig %0d regs %h want 0 0", trig_cyc1[1] - t1, bus1.regs_out);
    end
    send_frame(2'b10, 8'h2A, 1'b1);
    send_frame(2'b10, 8'h30, 1'b1);
    n_vec++;
    if (bus1.regs_out !== 64'h00000000_0A000000) begin
      n_err++; $display("FAIL regs2_commit: got %h want 000000000a000000", bus1.regs_out);
    end
    n_vec++;
    if (trig_cyc1[1] - t1 !== 1 || lat_bad1 !== 0) begin
      n_err++; $display("FAIL regs2_trig: cycles %0d late %0d want 1 0", trig_cyc1[1] - t1, lat_bad1);
    end
    n_vec++;
    if (bv_cnt1 - bv1 !== 5) begin
      n_err++; $display("FAIL two_stop_bytes: got %0d want 5", bv_cnt1 - bv1);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'h27;
    int bv0;
    int fe0;
    set_rx(2'b01, 1'b0);
    wait_clks(DIV);
    for (int i = 0; i < 3; i++) begin
      set_rx(2'b01, b[i]);
      wait_clks(DIV);
    end
    set_rx(2'b01, b[3]);
    wait_clks(DIV / 2);
    reset = 1'b1;
    wait_clks(3);
    n_vec++;
    if (bus0.regs_out !== 128'd0 || bus0.sel_ch !== 3'd0 || bus0.trig !== 4'd0) begin
      n_err++; $display("FAIL midframe_reset_regs: regs %h sel %0d trig %b want 0",
                        bus0.regs_out, bus0.sel_ch, bus0.trig);
    end
    n_vec++;
    if (bus0.rx_byte !== 8'd0 || bus0.byte_valid !== 1'b0 || bus0.frame_err !== 1'b0) begin
      n_err++; $display("FAIL midframe_reset_rx: byte %h bv %b fe %b want 0",
                        bus0.rx_byte, bus0.byte_valid, bus0.frame_err);
    end
    bv0 = bv_cnt0;
    fe0 = fe_cnt0;
    reset = 1'b0;
    wait_clks(2 * DIV);
    set_rx(2'b01, 1'b1);
    wait_clks(3 * DIV);
    send_frame(2'b01, 8'h27, 1'b1);
    n_vec++;
    if (bv_cnt0 - bv0 !== 1 || fe_cnt0 - fe0 !== 0 || bus0.rx_byte !== 8'h27) begin
      n_err++; $display("FAIL after_reset_rx: bv %0d fe %0d byte %h want 1 0 27",
                        bv_cnt0 - bv0, fe_cnt0 - fe0, bus0.rx_byte);
    end
  endtask

  initial begin
    test_reset();
    test_load_ch0();
    test_select_ch2();
    test_partial_commit();
    test_frame_err();
    test_ignore();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
